uart_tx_arbiter: RTL and testbench

Shares one `uart_peripheral` transmit path between `NUM_REQ` byte-stream requesters, such as the two issue slots and a debug port. Arbitration is round-robin at frame granularity: once a requester is granted, every byte up to and including its `last` byte is sent before any other requester gets the path. The block also owns the peripheral's `TX_config_register`. It applies a new configuration only after the TX path has fully drained, so no frame is ever transmitted with mixed settings. The block sits between the requesters and the peripheral's `TX_use` / `data_in` / `TX_available` / `TX_complete` pins.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_arb_pkg: arbiter state encoding and config reset default    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_CFG_WAIT  = 2'd2,
    ST_CFG_DRAIN = 2'd3
  } arb_state_e;

  localparam logic [7:0] CFG_RESET_DEFAULT = 8'h00;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter_if: requester, config and peripheral TX signals  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cfg_wr;
  logic [DATA_WIDTH-1:0]         cfg_data;
  logic                          cfg_busy;
  logic                          tx_use;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic [DATA_WIDTH-1:0]         tx_config_register;
  logic                          tx_available;
  logic                          tx_complete;
  logic                          grant_valid;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;

  // The arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, cfg_wr, cfg_data, tx_available, tx_complete,
    output req_ready, cfg_busy, tx_use, tx_data, tx_config_register, grant_valid, grant_id
  );

  // Requesters, config writer and peripheral seen as one environment.
  modport master (
    output req_valid, req_data, req_last, cfg_wr, cfg_data, tx_available, tx_complete,
    input  req_ready, cfg_busy, tx_use, tx_data, tx_config_register, grant_valid, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick: combinational round-robin selector starting after ptr   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int W = $clog2(N);

  int c;

  always_comb begin
    idx = '0;
    c   = 0;
    // Farthest candidate first, so the nearest valid index after ptr is written last.
    for (int i = N; i >= 1; i--) begin
      c = (int'(ptr) + i) % N;
      if (valid[c]) idx = W'(c);
    end
  end

  assign any = |valid;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter: frame-granular round-robin sharing of one UART  |
// | TX path, with drained application of TX configuration changes.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int                    NUM_REQ      = 2,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] CFG_RESET    = DATA_WIDTH'(CFG_RESET_DEFAULT),
  parameter logic [15:0]           DRAIN_CYCLES = 16'd20000
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_e            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  cfg_pending;
  logic [DATA_WIDTH-1:0] cfg_shadow;
  logic [15:0]           drain_cnt;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  accept_last;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_valid     = bus.req_valid[bus.grant_id];
    sel_last      = bus.req_last[bus.grant_id];
    bus.tx_data   = bus.req_data[int'(bus.grant_id)*DATA_WIDTH +: DATA_WIDTH];
    bus.req_ready = '0;
    bus.tx_use    = 1'b0;
    if (state == ST_GRANT) begin
      bus.req_ready[bus.grant_id] = bus.tx_available;
      bus.tx_use                  = sel_valid && bus.tx_available;
    end
  end

  assign accept_last  = bus.tx_use && sel_last;
  assign bus.cfg_busy = cfg_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= ST_IDLE;
      rr_ptr                 <= IW'(NUM_REQ - 1);
      bus.grant_valid        <= 1'b0;
      bus.grant_id           <= '0;
      cfg_pending            <= 1'b0;
      cfg_shadow             <= CFG_RESET;
      drain_cnt              <= '0;
      bus.tx_config_register <= CFG_RESET;
    end else begin
      if (bus.cfg_wr) begin
        cfg_shadow  <= bus.cfg_data;
        cfg_pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cfg_pending) begin
            state <= ST_CFG_WAIT;
          end else if (pick_any) begin
            bus.grant_id    <= pick_idx;
            bus.grant_valid <= 1'b1;
            state           <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (accept_last) begin
            rr_ptr          <= bus.grant_id;
            bus.grant_valid <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        ST_CFG_WAIT: begin
          if (bus.tx_complete) begin
            drain_cnt <= DRAIN_CYCLES;
            state     <= ST_CFG_DRAIN;
          end
        end
        ST_CFG_DRAIN: begin
          if (!bus.tx_complete) begin
            state <= ST_CFG_WAIT;
          end else if (drain_cnt == '0) begin
            bus.tx_config_register <= cfg_shadow;
            // A write landing on the apply cycle stays pending for another pass.
            if (!bus.cfg_wr) cfg_pending <= 1'b0;
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed and randomized frame/config checks  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  localparam int         NR      = 2;
  localparam int         DW      = 8;
  localparam int         DRAIN   = 10;
  localparam logic [7:0] CFG_RST = 8'h00;

  typedef struct packed {
    logic [7:0] id;
    logic       last;
    logic [7:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   tests;
  int   fails;

  logic [8:0] rq [NR][$];
  int         rp [NR];
  ent_t       expq [$];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .CFG_RESET    (CFG_RST),
    .DRAIN_CYCLES (16'(DRAIN))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
    bus.req_valid[i]          = v;
    bus.req_data[i*DW +: DW]  = d;
    bus.req_last[i]           = l;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.req_valid    = '0;
    bus.req_last     = '0;
    bus.req_data     = '0;
    bus.cfg_wr       = 1'b0;
    bus.cfg_data     = '0;
    bus.tx_available = 1'b0;
    bus.tx_complete  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Frame-level reference: whole frames leave in rotation order among requesters with frames left.
  task automatic build_expected();
    int   pos [NR];
    int   ptr;
    int   c;
    int   j;
    ent_t e;
    expq.delete();
    for (int i = 0; i < NR; i++) begin
      pos[i] = 0;
      rp[i]  = 0;
    end
    ptr = NR - 1;
    while (1) begin
      c = -1;
      for (int k = 1; k <= NR; k++) begin
        j = (ptr + k) % NR;
        if (c < 0 && pos[j] < rq[j].size()) c = j;
      end
      if (c < 0) break;
      do begin
        e.id   = 8'(c);
        e.last = rq[c][pos[c]][8];
        e.data = rq[c][pos[c]][7:0];
        expq.push_back(e);
        pos[c]++;
      end while (!e.last);
      ptr = c;
    end
  endtask

  task automatic run_stream(input int drop_pct, input int stall_pct, input bit chk_gap);
    int         guard;
    int         idle_run;
    int         ai;
    bit         first;
    bit         prev_last;
    bit         fof;
    bit         v;
    bit         avail;
    logic [NR-1:0] acc;
    ent_t       e;
    do_reset();
    build_expected();
    guard     = 0;
    idle_run  = 0;
    first     = 1'b1;
    prev_last = 1'b0;
    while (expq.size() > 0 && guard < 3000) begin
      guard++;
      for (int i = 0; i < NR; i++) begin
        if (rp[i] < rq[i].size()) begin
          // Valid may only drop mid-frame, keeping frame-start arbitration deterministic.
          fof = (rp[i] == 0) || rq[i][rp[i]-1][8];
          v   = fof || ($urandom_range(99, 0) >= drop_pct);
          set_req(i, v, rq[i][rp[i]][7:0], rq[i][rp[i]][8]);
        end else begin
          set_req(i, 1'b0, 8'h00, 1'b0);
        end
      end
      avail            = ($urandom_range(99, 0) >= stall_pct);
      bus.tx_available = avail;
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      chk("use_vs_accept", 32'(bus.tx_use), 32'(|acc));
      if (!avail) chk("stall_ready", 32'(bus.req_ready), 0);
      if (bus.tx_use) begin
        ai = -1;
        for (int i = 0; i < NR; i++) if (acc[i]) ai = i;
        e = expq.pop_front();
        chk("byte_gid", 32'(bus.grant_id), 32'(e.id));
        chk("byte_src", ai, 32'(e.id));
        chk("byte_data", 32'(bus.tx_data), 32'(e.data));
        if (chk_gap && !first) chk("frame_gap", idle_run, prev_last ? 1 : 0);
        first     = 1'b0;
        prev_last = e.last;
        idle_run  = 0;
        if (ai >= 0) rp[ai]++;
      end else begin
        idle_run++;
      end
      step();
    end
    chk("stream_done", expq.size(), 0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int n;
    bit seen11;
    tests = 0;
    fails = 0;

    // Reset state
    do_reset();
    set_req(0, 1'b0, 8'h5A, 1'b0);
    set_req(1, 1'b0, 8'hC3, 1'b0);
    @(negedge clk);
    chk("rst_grant_valid", 32'(bus.grant_valid), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_cfg_busy", 32'(bus.cfg_busy), 0);
    chk("rst_cfg_reg", 32'(bus.tx_config_register), 32'(CFG_RST));
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_tx_use", 32'(bus.tx_use), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h5A);

    // Single requester, 3-byte frame
    step();
    set_req(0, 1'b1, 8'hA1, 1'b0);
    bus.tx_available = 1'b1;
    @(negedge clk);
    chk("single_latency", 32'(bus.grant_valid), 0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("single_use", 32'(bus.tx_use), 1);
      chk("single_data", 32'(bus.tx_data), 32'h0A1 + k);
      chk("single_gid", 32'(bus.grant_id), 0);
      step();
      if (k < 2) set_req(0, 1'b1, 8'(8'hA2 + k), k == 1);
      else       set_req(0, 1'b0, 8'h00, 1'b0);
    end
    @(negedge clk);
    chk("single_release", 32'(bus.grant_valid), 0);
    chk("single_idle_use", 32'(bus.tx_use), 0);

    // Backpressure: 4-cycle stall after the second byte
    step();
    set_req(0, 1'b1, 8'hB0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_use", 32'(bus.tx_use), 1);
      chk("bp_data", 32'(bus.tx_data), 32'h0B0 + k);
      step();
      if (k < 3) set_req(0, 1'b1, 8'(8'hB1 + k), k == 2);
      else       set_req(0, 1'b0, 8'h00, 1'b0);
      if (k == 1) begin
        bus.tx_available = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_stall_ready", 32'(bus.req_ready), 0);
          chk("bp_stall_use", 32'(bus.tx_use), 0);
          step();
        end
        bus.tx_available = 1'b1;
      end
    end
    @(negedge clk);
    chk("bp_release", 32'(bus.grant_valid), 0);

    // Round-robin with back-to-back 2-byte frames
    for (int i = 0; i < NR; i++) rq[i].delete();
    rq[0].push_back(9'h010); rq[0].push_back(9'h111);
    rq[0].push_back(9'h012); rq[0].push_back(9'h113);
    rq[1].push_back(9'h020); rq[1].push_back(9'h121);
    rq[1].push_back(9'h022); rq[1].push_back(9'h123);
    run_stream(0, 0, 1'b1);

    // Randomized frames with mid-frame valid gaps and TX stalls
    for (int i = 0; i < NR; i++) begin
      int nf;
      int len;
      rq[i].delete();
      nf = int'($urandom_range(6, 3));
      for (int f = 0; f < nf; f++) begin
        len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
      end
    end
    run_stream(25, 30, 1'b0);

    // Config write during a 5-byte frame
    bus.tx_available = 1'b1;
    bus.tx_complete  = 1'b0;
    set_req(1, 1'b1, 8'hC0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("cfgf_use", 32'(bus.tx_use), 1);
      chk("cfgf_data", 32'(bus.tx_data), 32'h0C0 + k);
      chk("cfgf_gid", 32'(bus.grant_id), 1);
      step();
      bus.cfg_wr   = (k == 1);
      bus.cfg_data = 8'h6D;
      if (k < 4) set_req(1, 1'b1, 8'(8'hC1 + k), k == 3);
      else begin
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'hD0, 1'b1);
      end
    end
    repeat (6) begin
      @(negedge clk);
      chk("cfgf_hold_grant", 32'(bus.grant_valid), 0);
      chk("cfgf_hold_use", 32'(bus.tx_use), 0);
      chk("cfgf_hold_busy", 32'(bus.cfg_busy), 1);
      chk("cfgf_hold_reg", 32'(bus.tx_config_register), 32'(CFG_RST));
      step();
    end
    bus.tx_complete = 1'b1;
    n = 0;
    while (bus.tx_config_register !== 8'h6D && n < 40) begin
      step();
      n++;
    end
    // n counts edges from the drive point, so the sampling edge itself adds one.
    chk("cfgf_apply_latency", n, (DRAIN + 1) + 1);
    chk("cfgf_busy_clear", 32'(bus.cfg_busy), 0);
    step();
    @(negedge clk);
    chk("cfgf_next_grant", 32'(bus.grant_valid), 1);
    chk("cfgf_next_gid", 32'(bus.grant_id), 0);
    chk("cfgf_next_data", 32'(bus.tx_data), 32'h0D0);
    step();
    set_req(0, 1'b0, 8'h00, 1'b0);

    // Config overwrite: 8'h11 then 8'h22 during drain, only 8'h22 lands
    bus.cfg_wr   = 1'b1;
    bus.cfg_data = 8'h11;
    n      = 0;
    seen11 = 1'b0;
    while (bus.tx_config_register !== 8'h22 && n < 40) begin
      step();
      n++;
      if (bus.tx_config_register === 8'h11) seen11 = 1'b1;
      bus.cfg_wr = (n == 4);
      if (n == 4) bus.cfg_data = 8'h22;
    end
    chk("ow_latency", n, (DRAIN + 3) + 1);
    chk("ow_no_first_value", 32'(seen11), 0);
    chk("ow_busy_clear", 32'(bus.cfg_busy), 0);

    // Reset while draining
    bus.cfg_wr   = 1'b1;
    bus.cfg_data = 8'h33;
    repeat (6) begin
      step();
      bus.cfg_wr = 1'b0;
    end
    chk("rd_busy_pre", 32'(bus.cfg_busy), 1);
    rst = 1'b1;
    set_req(0, 1'b1, 8'hE0, 1'b1);
    set_req(1, 1'b1, 8'hF0, 1'b1);
    step();
    chk("rd_cfg_reg", 32'(bus.tx_config_register), 32'(CFG_RST));
    chk("rd_cfg_busy", 32'(bus.cfg_busy), 0);
    chk("rd_grant_valid", 32'(bus.grant_valid), 0);
    rst = 1'b0;
    step();
    chk("rd_idle_grant", 32'(bus.grant_valid), 1);
    chk("rd_idle_gid", 32'(bus.grant_id), 0);
    step();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (15) step();
    chk("rd_discarded", 32'(bus.tx_config_register), 32'(CFG_RST));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
